// File: rtl/mem_test_pkg.sv
// rtl/mem_test_pkg.sv - state encodings and pattern mode constants for the memory test controller
package mem_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_THERM   = 2'd0,
    MODE_INCR    = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_t;

endpackage

// File: rtl/memory_pattern_gen.sv
// rtl/memory_pattern_gen.sv - combinational test pattern for a given mode and address
module memory_pattern_gen
  import mem_test_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    case (mode)
      MODE_THERM: begin
        for (int i = 0; i < DATA_W; i++) data[i] = (i <= int'(addr));
      end
      MODE_INCR:  data = DATA_W'(addr);
      MODE_WALK:  data[int'(addr) % DATA_W] = 1'b1;
      default: begin
        // MSB is always 1 on even addresses; odd addresses get the inverse
        for (int i = 0; i < DATA_W; i++) data[i] = (((DATA_W - 1 - i) % 2) == 0) ^ addr[0];
      end
    endcase
  end

endmodule

// File: rtl/memory_test_ctrl.sv
// rtl/memory_test_ctrl.sv - write/read-back memory pass controller with pattern select
// Define MEMORY_TEST_CTRL_CHECK_EN to enable the read-back comparator (err, err_cnt).
module memory_test_ctrl
  import mem_test_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int DWELL_MAX = 3
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] disp_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   err_cnt
);

  localparam int DW_W = $clog2(DWELL_MAX);
  localparam logic [ADDR_W-1:0] ADDR_LAST    = {ADDR_W{1'b1}};
  localparam logic [DW_W-1:0]   DWELL_LAST   = DW_W'(DWELL_MAX - 1);
  localparam logic [DW_W-1:0]   DWELL_SAMPLE = DW_W'(1);

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ena_q, ena_d, wea_q, wea_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic                done_q, done_d;
  logic                pass_start, sample;
  logic [DATA_W-1:0]   wr_pat, exp_pat;

  memory_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr_pat (
    .mode (mode_q),
    .addr (addr_q),
    .data (wr_pat)
  );

  memory_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_exp_pat (
    .mode (mode_q),
    .addr (addr_q),
    .data (exp_pat)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_THERM;
      addr_q  <= '0;
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      dwell_q <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      dwell_q <= dwell_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    ena_d      = ena_q;
    wea_d      = wea_q;
    dwell_d    = dwell_q;
    disp_d     = disp_q;
    done_d     = done_q;
    pass_start = 1'b0;
    sample     = 1'b0;
    if (!locked) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      ena_d   = 1'b0;
      wea_d   = 1'b0;
      dwell_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_WRITE;
            mode_d     = mode_t'(mode);
            addr_d     = '0;
            ena_d      = 1'b1;
            wea_d      = 1'b1;
            dwell_d    = '0;
            done_d     = 1'b0;
            pass_start = 1'b1;
          end
        end
        ST_WRITE: begin
          if (addr_q == ADDR_LAST) begin
            state_d = ST_READ;
            addr_d  = '0;
            wea_d   = 1'b0;
            dwell_d = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        default: begin
          // Read data for addr_q is valid from the second dwell cycle onward
          if (dwell_q == DWELL_SAMPLE) begin
            disp_d = rd_data;
            sample = 1'b1;
          end
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (addr_q == ADDR_LAST) begin
              state_d = ST_DONE;
              ena_d   = 1'b0;
              done_d  = 1'b1;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef MEMORY_TEST_CTRL_CHECK_EN
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic            err_q;
  logic [ADDR_W:0] err_cnt_q;

  // Loss of lock clears the flag but keeps the count for inspection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (!locked) begin
      err_q <= 1'b0;
    end else if (pass_start) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (sample && (rd_data != exp_pat)) begin
      err_q <= 1'b1;
      if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_chk;
  assign unused_chk = ^{sample, pass_start, exp_pat};
  assign err        = 1'b0;
  assign err_cnt    = '0;
`endif

  assign state     = state_q;
  assign ena       = ena_q;
  assign wea       = wea_q;
  assign addr      = addr_q;
  assign wr_data   = (state_q == ST_WRITE) ? wr_pat : '0;
  assign disp_data = disp_q;
  assign done      = done_q;

endmodule

// File: doc/memory_test_ctrl.md
MEMORY_TEST_CTRL -- requirements
Module: memory_test_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, memory word width in bits (>= 2).
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter DWELL_MAX, default 3, clk_in cycles spent per address in the read phase (>= 2).
REQ-004 clk_in  input  1  single clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 locked  input  1  clock-source lock indicator; low acts as synchronous return to IDLE.
REQ-007 start  input  1  level request to begin a write/read pass.
REQ-008 mode  input  2  pattern select: 0 thermometer, 1 incrementing, 2 walking-one, 3 checkerboard.
REQ-009 rd_data  input  DATA_W  memory read port; valid one cycle after ena with wea low.
REQ-010 state  output  2  0 IDLE, 1 WRITE, 2 READ, 3 DONE.
REQ-011 ena / wea  output  1 each  memory enable / write enable, registered.
REQ-012 addr  output  ADDR_W  memory address, registered.
REQ-013 wr_data  output  DATA_W  write data, pattern(mode_q, addr).
REQ-014 disp_data  output  DATA_W  last word read back, held for display.
REQ-015 done / err  output  1 each  pass finished / at least one mismatch in this pass.
REQ-016 err_cnt  output  ADDR_W+1  number of mismatching addresses, saturating at DEPTH.

Function
REQ-017 IDLE: ena=wea=0, addr=0; start=1 latches mode into mode_q and enters WRITE next cycle.
REQ-018 WRITE: ena=wea=1 each cycle, addr increments 0..DEPTH-1, one word per cycle; exactly DEPTH write cycles.
REQ-019 Cycle after addr==DEPTH-1 in WRITE: state READ, addr=0, wea=0, ena=1; dwell counter cleared.
REQ-020 READ: addr held for DWELL_MAX cycles; dwell counter 0..DWELL_MAX-1, addr advances when counter==DWELL_MAX-1.
REQ-021 READ sample point: at dwell counter==1, rd_data captured into disp_data and compared with pattern(mode_q, addr).
REQ-022 After the last address's dwell completes: state DONE, ena=0, done=1, addr holds DEPTH-1, disp_data holds.
REQ-023 DONE: start=1 re-runs from WRITE with newly latched mode; err, err_cnt, done cleared on that transition.
REQ-024 start while WRITE or READ is ignored; mode changes after latching have no effect.
REQ-025 Thermometer: low min(addr+1, DATA_W) bits set, rest zero.
REQ-026 Incrementing: addr zero-extended to DATA_W; walking-one: 1 << (addr mod DATA_W).
REQ-027 Checkerboard: alternating 1010.. (MSB=1) for even addr, 0101.. for odd addr.
REQ-028 wr_data=0 outside WRITE.
REQ-029 locked low in any state: next cycle IDLE, outputs at reset values except err_cnt and disp_data, which hold.

Reset
REQ-030 rst_n low asynchronously forces state=IDLE, ena=wea=0, addr=0, wr_data=0, disp_data=0, done=err=0, err_cnt=0, mode_q=0, dwell counter 0.
REQ-031 rst_n mid-pass abandons the pass; no memory write occurs after assertion.

Configuration
REQ-032 Macro MEMORY_TEST_CTRL_CHECK_EN defined: compare logic, err and err_cnt active per REQ-021.
REQ-033 Macro undefined: no comparator; err and err_cnt tied to 0; disp_data capture and timing unchanged.

Structure
REQ-034 Shared package mem_test_pkg holds state encodings and mode constants.
REQ-035 Pattern function in sub-module memory_pattern_gen (combinational, parameter DATA_W, ADDR_W), instanced twice: write path and expected path.

Verification (DATA_W=16, ADDR_W=4, DWELL_MAX=3)
REQ-036 start=1, mode=0, memory model ideal -> 16 write cycles, addr 5 writes 0x003F, addr 15 writes 0xFFFF; done after 48 read cycles, err=0.
REQ-037 mode=2, memory model flips bit 0 at addr 3 -> err=1, err_cnt=1, disp_data=0x0009 captured at addr 3.
REQ-038 mode=3 -> addr 0 writes 0xAAAA, addr 1 writes 0x5555; start toggled during READ -> no restart.
REQ-039 rst_n pulsed low at WRITE addr 7 -> wea=0 immediately, state IDLE, all outputs at reset values.
REQ-040 locked dropped during READ addr 4 -> IDLE next cycle, err_cnt held; DONE then start with mode=1 -> addr 9 writes 0x0009, err cleared.
